video_timing_monitor: RTL and testbench
=======================================

# video_timing_monitor

Receive-side checker for the display timing interface: consumes the `hs`/`vs`/`hen`/`ven` strobes produced by the display timing generator, measures line and frame geometry, and asserts `lock` once the stream matches the expected mode for consecutive frames. It also produces active-pixel coordinates for downstream pixel sinks (framebuffer readback checker, overlay logic). It sits in the `pclk` domain directly after the timing generator.

## Interface
- `HTOT`, 1040, expected pclk cycles per line
- `HACT`, 800, expected active pixels per line
- `VTOT`, 666, expected lines per frame
- `VACT`, 600, expected active lines per frame
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..15)

- `pclk` in 1: pixel clock
- `rst` in 1: asynchronous, active-low reset
- `hs` in 1: horizontal sync, active-high
- `vs` in 1: vertical sync, active-high
- `hen` in 1: horizontal active enable
- `ven` in 1: vertical active enable
- `lock` out 1: mode locked
- `frame_ok` out 1: single-cycle pulse per good frame
- `frame_bad` out 1: single-cycle pulse per bad frame
- `meas_htot` out 11: last measured line period
- `meas_hact` out 11: last nonzero active-pixel count
- `meas_vtot` out 10: last measured lines per frame
- `meas_vact` out 10: last measured active lines
- `pvalid` out 1: registered `hen & ven & lock`
- `px` out 11: active pixel index
- `py` out 10: active line index
- `err_cnt` out 16: bad-frame counter (see Configuration)

## Operation
- **Edge detection**
  - `hs_d`/`vs_d` registers; `hs_rise = hs & ~hs_d`, `vs_rise = vs & ~vs_d`.
- **Line counters**
  - `hcnt` (11 b) clears on `hs_rise`, otherwise increments, saturating at 2047.
  - `hact_cnt` counts `hen & ven` cycles and clears on `hs_rise`.
- **On `hs_rise` with `hs_seen` = 1**
  - Line period = `hcnt + 1`.
  - A line is bad if its period ≠ `HTOT`, or if `hact_cnt` ≠ 0 and `hact_cnt` ≠ `HACT`.
  - Any bad line sets the sticky `line_err` flag.
  - Nonzero `hact_cnt` increments `vact_cnt`.
  - `lcnt` counts every `hs_rise`, saturating at 1023.
  - `hs_seen` sets on the first `hs_rise`.
- **On `vs_rise` with `vs_seen` = 1**
  - Latch `meas_vtot = lcnt` and `meas_vact = vact_cnt`.
  - Good frame = (`line_err` = 0) && `lcnt` = `VTOT` && `vact_cnt` = `VACT`; pulse `frame_ok` or `frame_bad` accordingly.
  - Clear `lcnt`, `vact_cnt` and `line_err`.
- **On `vs_rise` with `vs_seen` = 0**
  - Clear the counters and set `vs_seen`.
  - Neither pulse is issued: the partial first frame is discarded.
- **`hs_rise` and `vs_rise` in the same cycle:** the line is counted into the closing frame first, then the frame is evaluated.
- **`meas_htot`** updates on every qualifying `hs_rise`.
- **`meas_hact`** updates only on a qualifying `hs_rise` with nonzero `hact_cnt`.
- **Lock FSM**
  - `SEARCH`: `good_cnt` = 0 on entry. A good frame increments `good_cnt`; reaching `LOCK_FRAMES` moves to `LOCKED`. A bad frame clears `good_cnt`.
  - `LOCKED`: a bad frame returns to `SEARCH`. `lcnt` exceeding `VTOT` (missing `vs`) returns to `SEARCH` immediately, without waiting for `vs_rise`.
  - `lock` = (state == `LOCKED`), registered.
- **Coordinates**
  - `px` increments on each `hen & ven` cycle and clears on `hs_rise`.
  - `py` increments on each `hs_rise` that closes an active line and clears on `vs_rise`.
  - The `px`/`py` outputs are registered copies, aligned with `pvalid`.
  - `px` wraps at 2047 and `py` at 1023.

## Timing
- **Reset values:** all outputs 0, FSM in `SEARCH`, `hs_seen`/`vs_seen` = 0, counters 0.
- **Edge-detect latency:** 1 cycle from a sync input rising to the corresponding `_rise`. Measurements and `frame_ok`/`frame_bad` appear 1 cycle after the `_rise`.
- **`frame_ok`/`frame_bad`:** exactly one cycle wide, mutually exclusive.
- **`lock`:** rises the cycle after the `frame_ok` pulse that completes the `LOCK_FRAMES` count. It falls the cycle after the `frame_bad` pulse, or 1 cycle after `lcnt` passes `VTOT`.
- **Pixel outputs:** `pvalid`/`px`/`py` lag the inputs by 1 cycle; the first active pixel of a frame gives `px` = 0, `py` = 0.
- **Reset asserted mid-frame:** everything clears asynchronously. The next partial frame is discarded, so lock requires `LOCK_FRAMES` full frames after the first `vs_rise`.

## Configuration
- `VTM_ERRCNT_EN` defined:
  - `err_cnt` increments on every `frame_bad` and saturates at 65535.
  - It clears only on reset.
- Undefined:
  - No counter is built.
  - `err_cnt` is tied to 0, and the port list is unchanged.

## Test plan
- **Nominal lock:** generator defaults (1040/800/666/600) from reset → first `vs_rise` produces no pulse; `frame_ok` on the 2nd and 3rd `vs_rise`; `lock` = 1 after the 3rd; `meas_htot` = 1040, `meas_hact` = 800, `meas_vtot` = 666, `meas_vact` = 600.
- **Bad line:** while locked, inject one line of 1039 cycles → `frame_bad` at the next `vs_rise`, `lock` drops, `err_cnt` = 1 (with the macro); after 2 clean frames `lock` returns.
- **Missing vs:** while locked, suppress `vs` → `lock` falls 1 cycle after the 667th `hs_rise`.
- **Coordinates:** locked stream → last active pixel shows `px` = 799, `py` = 599, `pvalid` = 1; `pvalid` = 0 during blanking.
- **Reset mid-frame:** assert `rst` = 0 at line 300 → outputs 0 at once; after release the first `vs_rise` is discarded and `lock` reasserts after two good frames.
- **Wrong `vact`:** `ven` active for 599 lines → `frame_bad`, `meas_vact` = 599, `lock` stays 0 in `SEARCH`.

Source files
------------

// File: rtl/video_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_monitor
// Description : Receive-side checker for display timing strobes. Measures
//               line and frame geometry, declares lock after LOCK_FRAMES
//               consecutive good frames, and emits active-pixel coordinates.
// Ports       : pclk, rst (async, active-low)   clock / reset
//               hs, vs, hen, ven                 timing strobes in
//               lock, frame_ok, frame_bad        status
//               meas_htot/hact/vtot/vact         last measured geometry
//               pvalid, px, py                   active pixel coordinates
//               err_cnt                          bad-frame counter
// Options     : VTM_ERRCNT_EN - build the saturating bad-frame counter;
//               without it err_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_monitor #(
  parameter int HTOT        = 1040,
  parameter int HACT        = 800,
  parameter int VTOT        = 666,
  parameter int VACT        = 600,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic        hen,
  input  logic        ven,
  output logic        lock,
  output logic        frame_ok,
  output logic        frame_bad,
  output logic [10:0] meas_htot,
  output logic [10:0] meas_hact,
  output logic [9:0]  meas_vtot,
  output logic [9:0]  meas_vact,
  output logic        pvalid,
  output logic [10:0] px,
  output logic [9:0]  py,
  output logic [15:0] err_cnt
);

  localparam logic [11:0] c_htot        = 12'(HTOT);
  localparam logic [10:0] c_hact        = 11'(HACT);
  localparam logic [9:0]  c_vtot        = 10'(VTOT);
  localparam logic [9:0]  c_vact        = 10'(VACT);
  localparam logic [4:0]  c_lock_frames = 5'(LOCK_FRAMES);

  localparam logic [0:0] c_search = 1'b0;
  localparam logic [0:0] c_locked = 1'b1;

  logic        hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
  logic        hs_seen_q, hs_seen_d, vs_seen_q, vs_seen_d;
  logic [10:0] hcnt_q, hcnt_d, hact_cnt_q, hact_cnt_d;
  logic [9:0]  lcnt_q, lcnt_d, vact_cnt_q, vact_cnt_d;
  logic        line_err_q, line_err_d;
  logic        frame_ok_q, frame_ok_d, frame_bad_q, frame_bad_d;
  logic [10:0] meas_htot_q, meas_htot_d, meas_hact_q, meas_hact_d;
  logic [9:0]  meas_vtot_q, meas_vtot_d, meas_vact_q, meas_vact_d;
  logic        pvalid_q, pvalid_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic [0:0]  state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        lock_w;

  logic        w_hs_rise, w_vs_rise, w_line_evt, w_frame_evt;
  logic        w_hact_nz, w_line_bad, w_err_acc, w_frame_good;
  logic [9:0]  w_lcnt_inc, w_vact_inc;

  // Datapath: edge detect, line/frame measurement, coordinates.
  always_comb begin
    w_hs_rise   = hs & ~hs_dly_q;
    w_vs_rise   = vs & ~vs_dly_q;
    w_line_evt  = w_hs_rise & hs_seen_q;
    w_frame_evt = w_vs_rise & vs_seen_q;
    w_hact_nz   = (hact_cnt_q != 11'd0);
    w_line_bad  = (({1'b0, hcnt_q} + 12'd1) != c_htot) ||
                  (w_hact_nz && (hact_cnt_q != c_hact));

    // The closing line is folded into the frame totals before the frame
    // is judged, so a coincident hs/vs rise counts the line first.
    w_lcnt_inc   = (w_line_evt && (lcnt_q != 10'h3FF)) ? lcnt_q + 10'd1 : lcnt_q;
    w_vact_inc   = (w_line_evt && w_hact_nz) ? vact_cnt_q + 10'd1 : vact_cnt_q;
    w_err_acc    = line_err_q | (w_line_evt & w_line_bad);
    w_frame_good = ~w_err_acc && (w_lcnt_inc == c_vtot) && (w_vact_inc == c_vact);

    hs_dly_d   = hs;
    vs_dly_d   = vs;
    hs_seen_d  = hs_seen_q | w_hs_rise;
    vs_seen_d  = vs_seen_q;
    hcnt_d     = w_hs_rise ? 11'd0 :
                 ((hcnt_q == 11'h7FF) ? hcnt_q : hcnt_q + 11'd1);
    hact_cnt_d = (w_hs_rise ? 11'd0 : hact_cnt_q) + {10'd0, hen & ven};
    lcnt_d     = w_lcnt_inc;
    vact_cnt_d = w_vact_inc;
    line_err_d = w_err_acc;

    meas_htot_d = w_line_evt ? hcnt_q + 11'd1 : meas_htot_q;
    meas_hact_d = (w_line_evt && w_hact_nz) ? hact_cnt_q : meas_hact_q;
    meas_vtot_d = w_frame_evt ? w_lcnt_inc : meas_vtot_q;
    meas_vact_d = w_frame_evt ? w_vact_inc : meas_vact_q;
    frame_ok_d  = w_frame_evt & w_frame_good;
    frame_bad_d = w_frame_evt & ~w_frame_good;

    // Any vs rise starts a new frame; the first one only arms evaluation.
    if (w_vs_rise) begin
      lcnt_d     = 10'd0;
      vact_cnt_d = 10'd0;
      line_err_d = 1'b0;
      vs_seen_d  = 1'b1;
    end

    // Active-line counter doubles as the line coordinate.
    pvalid_d = hen & ven & lock_w;
    px_d     = w_hs_rise ? 11'd0 : hact_cnt_q;
    py_d     = vact_cnt_d;
  end

  // Lock FSM: next-state logic.
  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      c_search: begin
        if (frame_bad_q) begin
          good_cnt_d = 4'd0;
        end else if (frame_ok_q) begin
          if (({1'b0, good_cnt_q} + 5'd1) >= c_lock_frames) begin
            state_d    = c_locked;
            good_cnt_d = 4'd0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
      end
      c_locked: begin
        // Overrunning VTOT means vs went missing; drop without waiting.
        if (frame_bad_q || (lcnt_q > c_vtot)) begin
          state_d    = c_search;
          good_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = c_search;
        good_cnt_d = 4'd0;
      end
    endcase
  end

  // Lock FSM: output decode.
  always_comb begin
    lock_w = (state_q == c_locked);
  end

  // State register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hs_dly_q    <= 1'b0;
      vs_dly_q    <= 1'b0;
      hs_seen_q   <= 1'b0;
      vs_seen_q   <= 1'b0;
      hcnt_q      <= 11'd0;
      hact_cnt_q  <= 11'd0;
      lcnt_q      <= 10'd0;
      vact_cnt_q  <= 10'd0;
      line_err_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_bad_q <= 1'b0;
      meas_htot_q <= 11'd0;
      meas_hact_q <= 11'd0;
      meas_vtot_q <= 10'd0;
      meas_vact_q <= 10'd0;
      pvalid_q    <= 1'b0;
      px_q        <= 11'd0;
      py_q        <= 10'd0;
      state_q     <= c_search;
      good_cnt_q  <= 4'd0;
    end else begin
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
      hs_seen_q   <= hs_seen_d;
      vs_seen_q   <= vs_seen_d;
      hcnt_q      <= hcnt_d;
      hact_cnt_q  <= hact_cnt_d;
      lcnt_q      <= lcnt_d;
      vact_cnt_q  <= vact_cnt_d;
      line_err_q  <= line_err_d;
      frame_ok_q  <= frame_ok_d;
      frame_bad_q <= frame_bad_d;
      meas_htot_q <= meas_htot_d;
      meas_hact_q <= meas_hact_d;
      meas_vtot_q <= meas_vtot_d;
      meas_vact_q <= meas_vact_d;
      pvalid_q    <= pvalid_d;
      px_q        <= px_d;
      py_q        <= py_d;
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
    end
  end

`ifdef VTM_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_bad_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

  assign lock      = lock_w;
  assign frame_ok  = frame_ok_q;
  assign frame_bad = frame_bad_q;
  assign meas_htot = meas_htot_q;
  assign meas_hact = meas_hact_q;
  assign meas_vtot = meas_vtot_q;
  assign meas_vact = meas_vact_q;
  assign pvalid    = pvalid_q;
  assign px        = px_q;
  assign py        = py_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_monitor
// Description : Self-checking bench for video_timing_monitor using a reduced
//               video mode. Frames are described as line lists (length and
//               active pixel count) and a frame-level model predicts pulses,
//               measurements, lock and pixel coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_monitor;

  localparam int HTOT        = 20;
  localparam int HACT        = 12;
  localparam int VTOT        = 12;
  localparam int VACT        = 8;
  localparam int LOCK_FRAMES = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic        hs_i, vs_i, hen_i, ven_i;
  logic        lock, frame_ok, frame_bad, pvalid;
  logic [10:0] meas_htot, meas_hact, px;
  logic [9:0]  meas_vtot, meas_vact, py;
  logic [15:0] err_cnt;

  video_timing_monitor #(
    .HTOT(HTOT), .HACT(HACT), .VTOT(VTOT), .VACT(VACT), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .pclk(pclk), .rst(rst), .hs(hs_i), .vs(vs_i), .hen(hen_i), .ven(ven_i),
    .lock(lock), .frame_ok(frame_ok), .frame_bad(frame_bad),
    .meas_htot(meas_htot), .meas_hact(meas_hact),
    .meas_vtot(meas_vtot), .meas_vact(meas_vact),
    .pvalid(pvalid), .px(px), .py(py), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame description: per-line length and active pixel count (0 = blank).
  int n_lines;
  int llen [0:63];
  int lact [0:63];

  // Reference model state.
  bit hs_seen_m, vs_seen_m, lock_m, m_err;
  int good_m, last_htot, last_hact, m_lines, m_vact, mv_vtot, mv_vact, err_m;
  int prev_len, prev_act;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hs_seen_m = 0; vs_seen_m = 0; lock_m = 0; m_err = 0;
    good_m = 0; last_htot = 0; last_hact = 0; m_lines = 0; m_vact = 0;
    mv_vtot = 0; mv_vact = 0; err_m = 0;
  endtask

  function automatic int exp_err();
`ifdef VTM_ERRCNT_EN
    return err_m;
`else
    return 0;
`endif
  endfunction

  // A line of the given shape has just been terminated by an hs rise.
  task automatic line_close(input int len, input int act);
    if (hs_seen_m) begin
      last_htot = len;
      if (act != 0) begin
        last_hact = act;
        m_vact++;
      end
      if (len != HTOT || (act != 0 && act != HACT)) m_err = 1;
      m_lines++;
      if (lock_m && m_lines > VTOT) begin
        lock_m = 0;
        good_m = 0;
      end
    end
    hs_seen_m = 1;
  endtask

  task automatic frame_close(output bit ok, output bit bad);
    ok = 0; bad = 0;
    if (vs_seen_m) begin
      mv_vtot = m_lines;
      mv_vact = m_vact;
      if (!m_err && m_lines == VTOT && m_vact == VACT) begin
        ok = 1;
        if (!lock_m) begin
          good_m++;
          if (good_m == LOCK_FRAMES) lock_m = 1;
        end
      end else begin
        bad = 1;
        err_m++;
        good_m = 0;
        lock_m = 0;
      end
    end
    m_lines = 0; m_vact = 0; m_err = 0; vs_seen_m = 1;
  endtask

  // kind: 0 nominal, 1 one wrong-length line, 2 one active line short,
  // 3 one active line with wrong pixel count, 4 one line short per frame.
  task automatic gen_frame(input int kind);
    int r;
    n_lines = (kind == 4) ? VTOT - 1 : VTOT;
    for (int l = 0; l < n_lines; l++) begin
      llen[l] = HTOT;
      lact[l] = (l >= 2 && l < 2 + VACT) ? HACT : 0;
    end
    case (kind)
      1: begin
        r = $urandom_range(0, n_lines - 1);
        llen[r] = ($urandom_range(0, 1) == 0) ? HTOT - 1 : HTOT + 1;
      end
      2: lact[2 + VACT - 1] = 0;
      3: begin
        r = $urandom_range(2, 2 + VACT - 1);
        lact[r] = HACT - 1 - $urandom_range(0, 2);
      end
      default: ;
    endcase
  endtask

  task automatic check_all_zero(input string when);
    chk({when, " lock"}, lock, 0);
    chk({when, " frame_ok"}, frame_ok, 0);
    chk({when, " frame_bad"}, frame_bad, 0);
    chk({when, " meas_htot"}, meas_htot, 0);
    chk({when, " meas_hact"}, meas_hact, 0);
    chk({when, " meas_vtot"}, meas_vtot, 0);
    chk({when, " meas_vact"}, meas_vact, 0);
    chk({when, " pvalid"}, pvalid, 0);
    chk({when, " px"}, px, 0);
    chk({when, " py"}, py, 0);
    chk({when, " err_cnt"}, err_cnt, 0);
  endtask

  // Drives one frame from start_line; hs rises at every line start, vs rises
  // with line 0 when vs_en. Optionally pulses reset in the middle of rst_line.
  task automatic drive_frame(input bit vs_en, input int start_line, input int rst_line);
    bit lock_before, lock_after, exp_ok, exp_bad, act_prev;
    int hw;
    for (int l = start_line; l < n_lines; l++) begin
      lock_before = lock_m;
      line_close(prev_len, prev_act);
      exp_ok = 0; exp_bad = 0;
      if (vs_en && l == 0) frame_close(exp_ok, exp_bad);
      lock_after = lock_m;
      hw = (lact[l] != 0) ? lact[l] : HACT;
      for (int c = 0; c < llen[l]; c++) begin
        @(negedge pclk);
        if (c == 1) begin
          chk("frame_ok", frame_ok, exp_ok);
          chk("frame_bad", frame_bad, exp_bad);
          chk("lock_hold", lock, lock_before);
          chk("meas_htot", meas_htot, last_htot);
          chk("meas_hact", meas_hact, last_hact);
          chk("meas_vtot", meas_vtot, mv_vtot);
          chk("meas_vact", meas_vact, mv_vact);
          chk("err_cnt", err_cnt, exp_err());
        end
        if (c == 2) begin
          chk("frame_ok_width", frame_ok, 0);
          chk("frame_bad_width", frame_bad, 0);
          chk("lock", lock, lock_after);
        end
        if (c >= 3) begin
          act_prev = (lact[l] != 0) && (c - 1 >= 4) && (c - 1 < 4 + lact[l]);
          chk("pvalid", pvalid, act_prev && lock_after);
          if (act_prev && lock_after) begin
            chk("px", px, c - 5);
            chk("py", py, m_vact);
          end
        end
        if (l == rst_line && c == 10) begin
          rst = 1'b0;
          #1;
          check_all_zero("rst_mid");
          model_reset();
          lock_after = 0;
          repeat (3) @(negedge pclk);
          rst = 1'b1;
        end
        hs_i  = (c < 2);
        vs_i  = vs_en && (l < 2);
        hen_i = (c >= 4) && (c < 4 + hw);
        ven_i = (lact[l] != 0);
      end
      prev_len = llen[l];
      prev_act = lact[l];
    end
  endtask

  initial begin
    rst = 1'b0; hs_i = 0; vs_i = 0; hen_i = 0; ven_i = 0;
    prev_len = 0; prev_act = 0;
    model_reset();
    repeat (3) @(negedge pclk);
    check_all_zero("reset");
    rst = 1'b1;

    // Partial frame tail, then nominal frames up to lock and one locked frame.
    gen_frame(0);
    drive_frame(1'b1, 7, -1);
    for (int f = 0; f < 4; f++) begin
      gen_frame(0);
      drive_frame(1'b1, 0, -1);
    end

    // One bad line while locked, then recovery.
    gen_frame(1);
    drive_frame(1'b1, 0, -1);
    for (int f = 0; f < 3; f++) begin
      gen_frame(0);
      drive_frame(1'b1, 0, -1);
    end

    // Missing vs while locked.
    gen_frame(0);
    drive_frame(1'b0, 0, -1);
    gen_frame(0);
    drive_frame(1'b1, 0, -1);

    // Wrong active line count.
    gen_frame(2);
    drive_frame(1'b1, 0, -1);
    gen_frame(0);
    drive_frame(1'b1, 0, -1);

    // Randomised frame mix.
    for (int f = 0; f < 8; f++) begin
      gen_frame(($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 4)));
      drive_frame(1'b1, 0, -1);
    end

    // Reset in mid-frame, then relock.
    gen_frame(0);
    drive_frame(1'b1, 0, 5);
    for (int f = 0; f < 5; f++) begin
      gen_frame(0);
      drive_frame(1'b1, 0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
